race_controller: RTL
====================

Name: race_controller

Overview:
- Top-level race sequencer. Drives the 3-bit `state` bus shared by both car physics engines and pulses their reset at race start.
- Runs a 3-2-1 countdown, then tracks laps per car with checkpoint/finish-line zones on the cars' pos_x/pos_y.
- Declares the winner and freezes the race on pause or finish.
- Sits in the top level between the button inputs, the two physics engines and the display/HUD logic.

Parameters:
- CLK_FREQ, 100_000_000, system clock Hz; game tick period = CLK_FREQ/60 cycles.
- LAPS, 3, laps needed to win (1..7).
- FL_X0, 0; FL_X1, 40; FL_Y0, 110; FL_Y1, 130: finish zone, inclusive pixel bounds.
- CP_X0, 280; CP_X1, 319; CP_Y0, 110; CP_Y1, 130: checkpoint zone, inclusive bounds.
- FINISH_HOLD_S, 5, seconds in FINISH before auto-return to IDLE.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start_btn  in  1  debounced single-cycle pulse.
- pause_btn  in  1  debounced single-cycle pulse.
- p1_x, p1_y, p2_x, p2_y  in  10 each  car centre positions from the engines' pos_x/pos_y.
- state  out  3  0 IDLE, 1 COUNTDOWN, 2 PAUSE, 4 RACE, 5 FINISH; engines advance only on 4.
- car_rst  out  1  one-cycle pulse to both physics engines' rst.
- countdown  out  2  digit shown during COUNTDOWN (3,2,1), else 0.
- p1_lap, p2_lap  out  3 each  completed laps.
- winner  out  2  0 none, 1 P1, 2 P2, 3 tie.
- race_ticks  out  16  game ticks elapsed in RACE; saturates at 0xFFFF.

Behaviour:
- Reset (async, any time, including mid-race): state=IDLE; countdown=0; laps=0; winner=0; race_ticks=0; car_rst=0; tick counter=0; checkpoint flags clear.
- Tick: free-running counter 0..CLK_FREQ/60-1. tick=1 for one cycle when the counter is 0. Sec counter 0..59 advances on each tick.
- All outputs are registered.
- IDLE: start_btn -> COUNTDOWN next cycle. car_rst=1 that same cycle. countdown=3. Sec counter and laps, winner, race_ticks, flags all cleared.
- COUNTDOWN: after 60 ticks countdown decrements. When 60 ticks elapse at countdown=1 -> RACE, countdown=0. Buttons are ignored.
- RACE: on each tick, race_ticks++ (saturating), then per car:
  - in checkpoint zone -> cp_flag=1.
  - in finish zone with cp_flag=1 -> lap++ and cp_flag=0.
  - Finish zone with cp_flag=0 -> no effect. This blocks back-and-forth lap farming.
- Win check uses post-increment lap values in the same tick:
  - only P1 reaches LAPS -> winner=1.
  - only P2 reaches LAPS -> winner=2.
  - both in the same tick -> winner=3.
  - Any win -> FINISH next cycle.
- pause_btn in RACE -> PAUSE. In PAUSE, pause_btn -> RACE; tick and sec counters keep running, but race_ticks, laps and flags are frozen.
- start_btn in PAUSE -> IDLE (abort; winner stays 0).
- Simultaneous start_btn and pause_btn in PAUSE: start wins.
- start_btn in RACE: ignored.
- FINISH: laps, winner and race_ticks hold. Returns to IDLE on start_btn, or after FINISH_HOLD_S seconds, whichever comes first.
- On FINISH -> IDLE, outputs keep their values until the next start_btn clears them, so the HUD still shows results in IDLE.
- Zone tests: unsigned 10-bit compares, inclusive bounds.
- Lap counters never exceed LAPS, because the race leaves RACE on reaching it.

Decomposition:
- Shared package race_pkg holds the state encodings (ST_IDLE..ST_FINISH), the TICK_HZ=60 constant and the winner codes. PhysicsEngine compares against ST_RACE from the same package.
- One natural sub-module, lap_tracker: per-car zone compare, cp_flag and lap counter, instantiated twice, with the tick/enable/clear inputs driven by the controller FSM.

Test Plan (CLK_FREQ=600, so tick every 10 cycles; LAPS=2):
- Start: start_btn in IDLE -> car_rst high exactly 1 cycle; state=1, countdown=3. Countdown reads 2 after 600 cycles, 1 after 1200. state=4 at 1800 cycles; countdown=0.
- Lap: in RACE, P1 placed at (300,120) for 1 tick, then at (20,120) for 1 tick -> p1_lap=1. P1 held at (20,120) for another 5 ticks -> p1_lap stays 1.
- Tie: both cars at lap 1 with cp set, both moved into the finish zone in the same tick -> winner=3, state=5, race_ticks frozen.
- Pause: pause_btn in RACE -> state=2, race_ticks constant over 100 ticks. pause_btn again -> state=4 and race_ticks resumes. start_btn+pause_btn together in PAUSE -> state=0.
- Finish: P2 wins alone -> winner=2. No buttons for 5 seconds (3000 cycles) -> state=0 with p2_lap=2 retained. Next start_btn -> laps=0, winner=0.
- Async reset: rst asserted mid-RACE, between clock edges -> state=0 and all outputs zero immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/race_pkg.sv
// Shared race encodings: the state bus values seen by both physics engines,
// the game tick rate, winner codes and the rectangular zone helper.
package race_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_COUNTDOWN = 3'd1;
  localparam logic [2:0] ST_PAUSE     = 3'd2;
  localparam logic [2:0] ST_RACE      = 3'd4;
  localparam logic [2:0] ST_FINISH    = 3'd5;

  localparam int TICK_HZ = 60;

  typedef enum logic [1:0] {
    WIN_NONE = 2'd0,
    WIN_P1   = 2'd1,
    WIN_P2   = 2'd2,
    WIN_TIE  = 2'd3
  } winner_t;

  typedef struct packed {
    logic [9:0] x0;
    logic [9:0] x1;
    logic [9:0] y0;
    logic [9:0] y1;
  } zone_t;

  // Unsigned compares with inclusive bounds on both axes.
  function automatic logic in_zone(input logic [9:0] x, input logic [9:0] y, input zone_t z);
    return (x >= z.x0) && (x <= z.x1) && (y >= z.y0) && (y <= z.y1);
  endfunction

endpackage

// File: rtl/race_controller_if.sv
// Bundle between the race sequencer and the rest of the top level:
// buttons and car positions in, race state and HUD values out.
interface race_controller_if;

  logic        start_btn;
  logic        pause_btn;
  logic [9:0]  p1_x;
  logic [9:0]  p1_y;
  logic [9:0]  p2_x;
  logic [9:0]  p2_y;
  logic [2:0]  state;
  logic        car_rst;
  logic [1:0]  countdown;
  logic [2:0]  p1_lap;
  logic [2:0]  p2_lap;
  logic [1:0]  winner;
  logic [15:0] race_ticks;

  modport master (
    input  start_btn, pause_btn, p1_x, p1_y, p2_x, p2_y,
    output state, car_rst, countdown, p1_lap, p2_lap, winner, race_ticks
  );

  modport slave (
    output start_btn, pause_btn, p1_x, p1_y, p2_x, p2_y,
    input  state, car_rst, countdown, p1_lap, p2_lap, winner, race_ticks
  );

endinterface

// File: rtl/lap_tracker.sv
// Per-car lap counting: a checkpoint visit arms the car, the next finish-line
// visit on a game tick counts a lap and disarms it.
module lap_tracker
  import race_pkg::*;
#(
  parameter int FL_X0 = 0,
  parameter int FL_X1 = 40,
  parameter int FL_Y0 = 110,
  parameter int FL_Y1 = 130,
  parameter int CP_X0 = 280,
  parameter int CP_X1 = 319,
  parameter int CP_Y0 = 110,
  parameter int CP_Y1 = 130
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_en,
  input  logic       clear,
  input  logic [9:0] pos_x,
  input  logic [9:0] pos_y,
  output logic [2:0] lap,
  output logic       lap_hit
);

  localparam zone_t FL_ZONE = '{x0: 10'(FL_X0), x1: 10'(FL_X1), y0: 10'(FL_Y0), y1: 10'(FL_Y1)};
  localparam zone_t CP_ZONE = '{x0: 10'(CP_X0), x1: 10'(CP_X1), y0: 10'(CP_Y0), y1: 10'(CP_Y1)};

  logic in_fl;
  logic in_cp;
  logic cp_flag;

  assign in_fl = in_zone(pos_x, pos_y, FL_ZONE);
  assign in_cp = in_zone(pos_x, pos_y, CP_ZONE);

  // Checkpoint is evaluated before the finish line, so overlapping zones still count.
  assign lap_hit = tick_en && in_fl && (cp_flag || in_cp);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cp_flag <= 1'b0;
      lap     <= 3'd0;
    end else if (clear) begin
      cp_flag <= 1'b0;
      lap     <= 3'd0;
    end else if (tick_en) begin
      if (lap_hit) begin
        cp_flag <= 1'b0;
        lap     <= lap + 3'd1;
      end else if (in_cp) begin
        cp_flag <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/race_controller.sv
// Race sequencer: 3-2-1 countdown, lap tracking for two cars, pause/abort,
// winner declaration and a timed hold on the results screen.
module race_controller
  import race_pkg::*;
#(
  parameter int CLK_FREQ      = 100_000_000,
  parameter int LAPS          = 3,
  parameter int FL_X0         = 0,
  parameter int FL_X1         = 40,
  parameter int FL_Y0         = 110,
  parameter int FL_Y1         = 130,
  parameter int CP_X0         = 280,
  parameter int CP_X1         = 319,
  parameter int CP_Y0         = 110,
  parameter int CP_Y1         = 130,
  parameter int FINISH_HOLD_S = 5
) (
  input logic              clk,
  input logic              rst,
  race_controller_if.master bus
);

  localparam int TICK_DIV = CLK_FREQ / TICK_HZ;
  localparam int TCW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [TCW-1:0] tick_cnt;
  logic [5:0]     sec_cnt;
  logic [7:0]     fin_sec;
  logic [2:0]     state;
  logic [1:0]     countdown;
  winner_t        winner;
  logic [15:0]    race_ticks;
  logic           car_rst;

  logic       tick;
  logic       sec_wrap;
  logic       race_tick;
  logic       clear_run;
  logic [2:0] p1_lap;
  logic [2:0] p2_lap;
  logic       p1_hit;
  logic       p2_hit;
  logic       p1_win;
  logic       p2_win;

  assign tick      = (tick_cnt == '0);
  assign sec_wrap  = tick && (sec_cnt == 6'(TICK_HZ - 1));
  // A pause press on a tick cycle freezes the race before that tick is applied.
  assign race_tick = tick && (state == ST_RACE) && !bus.pause_btn;
  assign clear_run = (state == ST_IDLE) && bus.start_btn;

  // Win test uses the lap value that this very tick produces.
  assign p1_win = p1_hit && (p1_lap == 3'(LAPS - 1));
  assign p2_win = p2_hit && (p2_lap == 3'(LAPS - 1));

  lap_tracker #(
    .FL_X0(FL_X0), .FL_X1(FL_X1), .FL_Y0(FL_Y0), .FL_Y1(FL_Y1),
    .CP_X0(CP_X0), .CP_X1(CP_X1), .CP_Y0(CP_Y0), .CP_Y1(CP_Y1)
  ) u_lap_p1 (
    .clk(clk), .rst(rst), .tick_en(race_tick), .clear(clear_run),
    .pos_x(bus.p1_x), .pos_y(bus.p1_y), .lap(p1_lap), .lap_hit(p1_hit)
  );

  lap_tracker #(
    .FL_X0(FL_X0), .FL_X1(FL_X1), .FL_Y0(FL_Y0), .FL_Y1(FL_Y1),
    .CP_X0(CP_X0), .CP_X1(CP_X1), .CP_Y0(CP_Y0), .CP_Y1(CP_Y1)
  ) u_lap_p2 (
    .clk(clk), .rst(rst), .tick_en(race_tick), .clear(clear_run),
    .pos_x(bus.p2_x), .pos_y(bus.p2_y), .lap(p2_lap), .lap_hit(p2_hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt   <= '0;
      sec_cnt    <= 6'd0;
      fin_sec    <= 8'd0;
      state      <= ST_IDLE;
      countdown  <= 2'd0;
      winner     <= WIN_NONE;
      race_ticks <= 16'd0;
      car_rst    <= 1'b0;
    end else begin
      // NOTE: car_rst defaults low every cycle, so a set below can only ever
      // produce a single-cycle pulse.
      car_rst  <= 1'b0;
      tick_cnt <= (tick_cnt == TCW'(TICK_DIV - 1)) ? '0 : tick_cnt + 1'b1;
      if (tick) begin
        sec_cnt <= sec_wrap ? 6'd0 : sec_cnt + 6'd1;
      end

      case (state)
        ST_IDLE: begin
          if (bus.start_btn) begin
            state      <= ST_COUNTDOWN;
            car_rst    <= 1'b1;
            countdown  <= 2'd3;
            sec_cnt    <= 6'd0;
            winner     <= WIN_NONE;
            race_ticks <= 16'd0;
          end
        end

        ST_COUNTDOWN: begin
          if (sec_wrap) begin
            if (countdown == 2'd1) begin
              state     <= ST_RACE;
              countdown <= 2'd0;
            end else begin
              countdown <= countdown - 2'd1;
            end
          end
        end

        ST_RACE: begin
          if (bus.pause_btn) begin
            state <= ST_PAUSE;
          end else if (tick) begin
            if (race_ticks != 16'hFFFF) begin
              race_ticks <= race_ticks + 16'd1;
            end
            if (p1_win || p2_win) begin
              state   <= ST_FINISH;
              winner  <= winner_t'({p2_win, p1_win});
              sec_cnt <= 6'd0;
              fin_sec <= 8'd0;
            end
          end
        end

        ST_PAUSE: begin
          if (bus.start_btn) begin
            state <= ST_IDLE;
          end else if (bus.pause_btn) begin
            state <= ST_RACE;
          end
        end

        ST_FINISH: begin
          // The hold timer restarts at FINISH entry so the results show for whole seconds.
          if (bus.start_btn) begin
            state <= ST_IDLE;
          end else if (sec_wrap) begin
            if (fin_sec == 8'(FINISH_HOLD_S - 1)) begin
              state <= ST_IDLE;
            end else begin
              fin_sec <= fin_sec + 8'd1;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.state      = state;
  assign bus.car_rst    = car_rst;
  assign bus.countdown  = countdown;
  assign bus.p1_lap     = p1_lap;
  assign bus.p2_lap     = p2_lap;
  assign bus.winner     = winner;
  assign bus.race_ticks = race_ticks;

endmodule
